// File: rtl/stage1_pkg.sv
// Shared stage-1 types and width constants.
// Used by the write-back arbiter and its integration interface.
package stage1_pkg;

    localparam int P_NUM_REQ   = 4;
    localparam int P_DES       = 4;
    localparam int P_DATA_W    = 16;
    localparam int P_BRANCH_ID = 3;
    localparam int P_REG_NUM   = 1 << P_DES;

    typedef struct packed {
        logic                   valid;
        logic [P_DES-1:0]       des;
        logic [P_DATA_W-1:0]    data;
        logic [P_BRANCH_ID-1:0] branch_id;
    } wb_req_t;

    typedef enum logic [1:0] {
        REQ_ALU,
        REQ_MUL,
        REQ_LD,
        REQ_BR
    } req_idx_e;

endpackage

// File: rtl/wb_arbiter_interface.sv
// Bundle of write-back arbiter signals.
// Lets the top connect the arbiter like the other stage-1 blocks.
interface wb_arbiter_interface
    import stage1_pkg::*;
#(
    parameter int NUM_REQ   = P_NUM_REQ,
    parameter int des       = P_DES,
    parameter int DATA_W    = P_DATA_W,
    parameter int branch_id = P_BRANCH_ID,
    parameter int reg_num   = P_REG_NUM
) (
    input logic clk
);

    logic                           rst;
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ*des-1:0]         req_des;
    logic [NUM_REQ*DATA_W-1:0]      req_data;
    logic [NUM_REQ*branch_id-1:0]   req_branch_id;
    logic [NUM_REQ-1:0]             req_grant;
    logic                           issue_valid;
    logic [des-1:0]                 issue_des;
    logic                           flush;
    logic [branch_id-1:0]           flush_branch_id;
    logic                           wr_en;
    logic [des-1:0]                 wr_addr;
    logic [DATA_W-1:0]              wr_data;
    logic [reg_num-1:0]             busy;

    modport wb_arbiter_dut (
        input  clk, rst,
        input  req_valid, req_des, req_data, req_branch_id,
        input  issue_valid, issue_des,
        input  flush, flush_branch_id,
        output req_grant,
        output wr_en, wr_addr, wr_data, busy
    );

    modport wb_arbiter_bench (
        input  clk,
        output rst,
        output req_valid, req_des, req_data, req_branch_id,
        output issue_valid, issue_des,
        output flush, flush_branch_id,
        input  req_grant,
        input  wr_en, wr_addr, wr_data, busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first request at or above ptr, wrapping to index 0.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx
);

    logic found;

    // Upper half (>= ptr) searched first, then the wrapped lower half.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                gnt[i] = 1'b1;
                idx    = PW'(i);
                found  = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i < int'(ptr))) begin
                gnt[i] = 1'b1;
                idx    = PW'(i);
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter with busy scoreboard.
// Squashed results are granted and dropped; one real write per cycle.
module wb_arbiter
    import stage1_pkg::*;
#(
    parameter int NUM_REQ   = P_NUM_REQ,
    parameter int des       = P_DES,
    parameter int DATA_W    = P_DATA_W,
    parameter int branch_id = P_BRANCH_ID,
    parameter int reg_num   = P_REG_NUM
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*des-1:0]       req_des,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    input  logic [NUM_REQ*branch_id-1:0] req_branch_id,
    output logic [NUM_REQ-1:0]           req_grant,
    input  logic                         issue_valid,
    input  logic [des-1:0]               issue_des,
    input  logic                         flush,
    input  logic [branch_id-1:0]         flush_branch_id,
    output logic                         wr_en,
    output logic [des-1:0]               wr_addr,
    output logic [DATA_W-1:0]            wr_data,
    output logic [reg_num-1:0]           busy
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [des-1:0]       r_des  [NUM_REQ];
    logic [DATA_W-1:0]    r_data [NUM_REQ];
    logic [branch_id-1:0] r_tag  [NUM_REQ];

    logic [NUM_REQ-1:0] squash;
    logic [NUM_REQ-1:0] normal;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [PW-1:0]      winner;
    logic               have_win;

    logic [PW-1:0]      ptr_q, ptr_d;
    logic               wr_en_q, wr_en_d;
    logic [des-1:0]     wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic [reg_num-1:0] busy_q, busy_d;

    // Split the flat requester buses into per-requester fields.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            r_des[i]  = req_des[i*des +: des];
            r_data[i] = req_data[i*DATA_W +: DATA_W];
            r_tag[i]  = req_branch_id[i*branch_id +: branch_id];
        end
    end

    // Squash matches bypass arbitration; everything is masked in reset.
    always_comb begin
        squash = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            squash[i] = flush && req_valid[i] &&
                        (r_tag[i] == flush_branch_id);
        end
        normal = req_valid & ~squash;
        if (rst) begin
            squash = '0;
            normal = '0;
        end
    end

    rr_arbiter #(
        .N  (NUM_REQ),
        .PW (PW)
    ) u_rr (
        .req (normal),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (winner)
    );

    assign have_win  = |arb_gnt;
    assign req_grant = squash | arb_gnt;

    // Next-state: write port, rotation pointer and scoreboard.
    always_comb begin
        ptr_d     = ptr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        busy_d    = busy_q;
        if (have_win) begin
            ptr_d     = (winner == PW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
            wr_en_d   = 1'b1;
            wr_addr_d = r_des[winner];
            wr_data_d = r_data[winner];
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_grant[i]) begin
                busy_d[r_des[i]] = 1'b0;
            end
        end
        // A new producer outranks a completing older one.
        if (issue_valid) begin
            busy_d[issue_des] = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= '0;
        end else begin
            ptr_q     <= ptr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for the write-back arbiter.
// Vector table plus reset, rotation and mid-run reset sequences.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [15:0] req_des;
    logic [63:0] req_data;
    logic [11:0] req_branch_id;
    logic [3:0]  req_grant;
    logic        issue_valid;
    logic [3:0]  issue_des;
    logic        flush;
    logic [2:0]  flush_branch_id;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [15:0] busy;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0]  v;
        logic [15:0] d;
        logic [63:0] dat;
        logic [11:0] t;
        logic        fl;
        logic [2:0]  fid;
        logic        iv;
        logic [3:0]  ides;
        logic [3:0]  g;
        logic        en;
        logic [3:0]  a;
        logic [15:0] wd;
        logic [15:0] b;
    } vec_t;

    vec_t tbl [14];

    always #5 clk = ~clk;

    wb_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_des         (req_des),
        .req_data        (req_data),
        .req_branch_id   (req_branch_id),
        .req_grant       (req_grant),
        .issue_valid     (issue_valid),
        .issue_des       (issue_des),
        .flush           (flush),
        .flush_branch_id (flush_branch_id),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .busy            (busy)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        req_valid       = '0;
        req_des         = '0;
        req_data        = '0;
        req_branch_id   = '0;
        issue_valid     = 1'b0;
        issue_des       = '0;
        flush           = 1'b0;
        flush_branch_id = '0;
    endtask

    initial begin
        // valid des data tag fl fid iv ides | grant en addr data busy
        tbl[0]  = '{4'b0001, 16'h0005, 64'h0000_0000_0000_BEEF, 12'h000,
                    1'b0, 3'd0, 1'b0, 4'd0,
                    4'b0001, 1'b1, 4'h5, 16'hBEEF, 16'h0000};
        tbl[1]  = '{4'b1111, 16'h4321, 64'h00A3_00A2_00A1_00A0, 12'h000,
                    1'b0, 3'd0, 1'b0, 4'd0,
                    4'b0010, 1'b1, 4'h2, 16'h00A1, 16'h0000};
        tbl[2]  = '{4'b1111, 16'h4321, 64'h00A3_00A2_00A1_00A0, 12'h000,
                    1'b0, 3'd0, 1'b0, 4'd0,
                    4'b0100, 1'b1, 4'h3, 16'h00A2, 16'h0000};
        tbl[3]  = '{4'b1111, 16'h4321, 64'h00A3_00A2_00A1_00A0, 12'h000,
                    1'b0, 3'd0, 1'b0, 4'd0,
                    4'b1000, 1'b1, 4'h4, 16'h00A3, 16'h0000};
        tbl[4]  = '{4'b1111, 16'h4321, 64'h00A3_00A2_00A1_00A0, 12'h000,
                    1'b0, 3'd0, 1'b0, 4'd0,
                    4'b0001, 1'b1, 4'h1, 16'h00A0, 16'h0000};
        tbl[5]  = '{4'b0000, 16'h4321, 64'h00A3_00A2_00A1_00A0, 12'h000,
                    1'b0, 3'd0, 1'b1, 4'd3,
                    4'b0000, 1'b0, 4'h1, 16'h00A0, 16'h0008};
        tbl[6]  = '{4'b0100, 16'h0300, 64'h0000_3333_0000_0000, 12'h000,
                    1'b0, 3'd0, 1'b0, 4'd0,
                    4'b0100, 1'b1, 4'h3, 16'h3333, 16'h0000};
        tbl[7]  = '{4'b0001, 16'h0007, 64'h0000_0000_0000_7777, 12'h000,
                    1'b0, 3'd0, 1'b1, 4'd7,
                    4'b0001, 1'b1, 4'h7, 16'h7777, 16'h0080};
        tbl[8]  = '{4'b0011, 16'h00A9, 64'h0000_0000_AAAA_9999, 12'h022,
                    1'b1, 3'd2, 1'b0, 4'd0,
                    4'b0011, 1'b1, 4'hA, 16'hAAAA, 16'h0080};
        tbl[9]  = '{4'b0011, 16'h0021, 64'h0000_0000_2222_1111, 12'h000,
                    1'b0, 3'd0, 1'b1, 4'd12,
                    4'b0001, 1'b1, 4'h1, 16'h1111, 16'h1080};
        tbl[10] = '{4'b1000, 16'hC000, 64'h5555_0000_0000_0000, 12'hA00,
                    1'b1, 3'd5, 1'b0, 4'd0,
                    4'b1000, 1'b0, 4'h1, 16'h1111, 16'h0080};
        tbl[11] = '{4'b1001, 16'h7008, 64'h7070_0000_0000_8080, 12'h000,
                    1'b0, 3'd0, 1'b0, 4'd0,
                    4'b1000, 1'b1, 4'h7, 16'h7070, 16'h0000};
        tbl[12] = '{4'b1111, 16'h00F0, 64'h0000_0000_F00F_0000, 12'h6CB,
                    1'b1, 3'd3, 1'b0, 4'd0,
                    4'b1111, 1'b1, 4'hF, 16'hF00F, 16'h0000};
        tbl[13] = '{4'b0100, 16'h0F00, 64'h0000_DDDD_0000_0000, 12'h180,
                    1'b1, 3'd6, 1'b1, 4'd15,
                    4'b0100, 1'b0, 4'hF, 16'hF00F, 16'h8000};

        // Reset with activity on the inputs: nothing granted or recorded.
        clear_in();
        rst         = 1'b1;
        req_valid   = 4'b1111;
        issue_valid = 1'b1;
        issue_des   = 4'd5;
        #2;
        chk("grant in reset", 64'(req_grant), 64'h0);
        tick();
        tick();
        chk("reset wr_en", 64'(wr_en), 64'h0);
        chk("reset wr_addr", 64'(wr_addr), 64'h0);
        chk("reset wr_data", 64'(wr_data), 64'h0);
        chk("reset busy", 64'(busy), 64'h0);
        clear_in();
        rst = 1'b0;

        for (int k = 0; k < 14; k++) begin
            req_valid       = tbl[k].v;
            req_des         = tbl[k].d;
            req_data        = tbl[k].dat;
            req_branch_id   = tbl[k].t;
            flush           = tbl[k].fl;
            flush_branch_id = tbl[k].fid;
            issue_valid     = tbl[k].iv;
            issue_des       = tbl[k].ides;
            #1;
            chk($sformatf("v%0d grant", k), 64'(req_grant), 64'(tbl[k].g));
            tick();
            chk($sformatf("v%0d wr_en", k), 64'(wr_en), 64'(tbl[k].en));
            chk($sformatf("v%0d wr_addr", k), 64'(wr_addr), 64'(tbl[k].a));
            chk($sformatf("v%0d wr_data", k), 64'(wr_data), 64'(tbl[k].wd));
            chk($sformatf("v%0d busy", k), 64'(busy), 64'(tbl[k].b));
        end

        // Rotation from reset with all requesters held valid.
        clear_in();
        rst = 1'b1;
        tick();
        rst       = 1'b0;
        req_valid = 4'b1111;
        req_des   = 16'h4321;
        req_data  = 64'h00A3_00A2_00A1_00A0;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("rr%0d grant", k), 64'(req_grant),
                64'(4'b0001 << (k % 4)));
            tick();
            chk($sformatf("rr%0d wr_en", k), 64'(wr_en), 64'h1);
            chk($sformatf("rr%0d wr_addr", k), 64'(wr_addr),
                64'((k % 4) + 1));
        end

        // Reset in the cycle after a grant drops everything.
        clear_in();
        req_valid   = 4'b0001;
        req_des     = 16'h0005;
        req_data    = 64'h0000_0000_0000_BEEF;
        issue_valid = 1'b1;
        issue_des   = 4'd3;
        #1;
        chk("mid grant", 64'(req_grant), 64'h1);
        tick();
        chk("mid wr_en", 64'(wr_en), 64'h1);
        chk("mid busy", 64'(busy), 64'h0008);
        rst         = 1'b1;
        issue_valid = 1'b0;
        #1;
        chk("mid rst grant", 64'(req_grant), 64'h0);
        tick();
        chk("post rst wr_en", 64'(wr_en), 64'h0);
        chk("post rst busy", 64'(busy), 64'h0);
        chk("post rst wr_addr", 64'(wr_addr), 64'h0);
        clear_in();
        rst = 1'b0;
        tick();
        chk("idle wr_en", 64'(wr_en), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Register-file write-back arbiter and scoreboard controller for stage 1. Shares the single register_file write port between NUM_REQ completing functional units using round-robin arbitration. Squashes results belonging to a mispredicted branch. Keeps a per-register busy scoreboard that top_issue_stage reads to hold dependent instructions.

## Interface
Parameters:
- NUM_REQ, 4, number of write-back requesters (0 = ALU, 1 = MUL, 2 = LD, 3 = BR)
- des, 4, destination register index width
- DATA_W, 16, write data width
- branch_id, 3, branch tag width
- reg_num, 16, number of architectural registers (2**des)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; synchronous, active-high
- req_valid  in  NUM_REQ  requester i has a result
- req_des  in  NUM_REQ*des  destination of requester i (slice i)
- req_data  in  NUM_REQ*DATA_W  result of requester i
- req_branch_id  in  NUM_REQ*branch_id  branch tag of requester i
- req_grant  out  NUM_REQ  result accepted this cycle (combinational)
- issue_valid  in  1  issue stage dispatches an instruction this cycle
- issue_des  in  des  its destination register
- flush  in  1  branch mispredict this cycle
- flush_branch_id  in  branch_id  tag being squashed
- wr_en  out  1  register_file write enable (registered)
- wr_addr  out  des  register_file write address (registered)
- wr_data  out  DATA_W  register_file write data (registered)
- busy  out  reg_num  scoreboard; bit r = result for r pending (registered)

## Operation
- Handshake: a requester holds valid/des/data/branch_id stable until req_grant is high. Transfer happens when valid & grant. Grant is never high without valid.
- Squash: when flush=1, every valid requester with req_branch_id == flush_branch_id is granted in the same cycle, and its result is discarded (no write). Multiple squash grants in one cycle are allowed.
- Arbitration: among valid, non-squashed requesters, grant exactly one. Search starts at pointer ptr and goes upward, wrapping modulo NUM_REQ.
- ptr (clog2(NUM_REQ) bits, reset 0) becomes winner+1 mod NUM_REQ after a normal grant. ptr is unchanged when there is no normal grant or only squash grants.
- Write: a normal winner produces wr_en=1, wr_addr=req_des, wr_data=req_data on the next cycle. Otherwise wr_en=0, and wr_addr/wr_data hold their previous values.
- Scoreboard set: issue_valid sets busy[issue_des].
- Scoreboard clear: a normal grant clears busy[req_des]. A squash grant also clears busy[req_des]; there is no rename, so the squashed producer is gone.
- Conflict: set and clear of the same register in one cycle → set wins (newer producer).
- A grant to a register whose busy bit is already 0 writes normally; busy stays 0.
- All registers, including r0, are ordinary and writable.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, busy=0, ptr=0.
- While rst=1, req_grant=0 and all requests and issues are ignored.
- rst asserted mid-operation: the next edge clears all state. Any pending wr_en is dropped, and requesters must re-present.
- req_grant is combinational from req_valid, req_branch_id, flush, flush_branch_id and ptr.
- Grant-to-write latency is 1 cycle. The busy clear lands on the same edge that raises wr_en, so a consumer sees busy[r]=0 in the same cycle the write is presented.
- Throughput is one register write per cycle. With all NUM_REQ requesters continuously valid, each requester is granted exactly once every NUM_REQ cycles.
- issue → busy visible: 1 cycle.

## Structure
- stage1_pkg holds:
  - width constants (des, DATA_W, branch_id, reg_num, NUM_REQ);
  - typedef wb_req_t {valid, des, data, branch_id};
  - requester index enum (REQ_ALU, REQ_MUL, REQ_LD, REQ_BR).
- Sub-module rr_arbiter (parameter N): inputs are the request vector and ptr; outputs are a one-hot grant and the winner index. It is purely combinational, and ptr stays in wb_arbiter.
- wb_arbiter adds a wb_arbiter_interface with wb_arbiter_dut / wb_arbiter_bench modports, matching the other stage-1 blocks, for integration into top.

## Test plan
- Reset, then req_valid=4'b0001, des=5, data=16'hBEEF → grant=0001 same cycle; next cycle wr_en=1, wr_addr=5, wr_data=BEEF; ptr=1.
- All four requesters valid and held for 8 cycles from reset → grant sequence 0001, 0010, 0100, 1000, 0001, …; wr_addr follows each requester's des.
- issue_valid, issue_des=3 → busy[3]=1 next cycle. Later, requester 2 writes des=3 → busy[3]=0 in the cycle wr_en=1.
- Same cycle: issue_des=7 and a normal grant with des=7 → busy[7] stays 1 and wr_en=1 for r7.
- flush=1, flush_branch_id=2; requesters 0 and 1 valid with tags 2 and 4 → grant=0011. Next cycle, only requester 1's data is written; ptr=2.
- rst pulsed in the cycle after a grant → wr_en=0 and busy=0 on the following edge, with no write issued.
